// File: rtl/bcd3_seg_scanner.sv
// ============================================================================
// Module   : bcd3_seg_scanner
// Purpose  : Time-multiplexed 3-digit seven-segment driver with per-frame
//            snapshot, leading-zero blanking and dash for non-BCD codes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd3_seg_scanner #(
   parameter int unsigned REFRESH_DIV    = 50000,
   parameter bit          SEG_ACTIVE_LOW = 1'b1,
   parameter bit          AN_ACTIVE_LOW  = 1'b1,
   parameter bit          BLANK_LZ       = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] d1,
   input  logic [3:0] d10,
   input  logic [3:0] d100,
   output logic [6:0] seg,
   output logic [2:0] an,
   output logic       frame
);

   localparam int unsigned c_PW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [c_PW-1:0] c_TC  = c_PW'(REFRESH_DIV - 1);
   localparam logic [6:0] c_SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic [2:0] c_AN_OFF   = AN_ACTIVE_LOW  ? 3'b111 : 3'b000;

   typedef enum logic [1:0] {
      DIG0 = 2'd0,
      DIG1 = 2'd1,
      DIG2 = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [c_PW-1:0]   presc_q, presc_d;
   logic [11:0]       snap_q, snap_d;
   logic              load_pending_q, load_pending_d;
   logic [6:0]        seg_q, seg_d;
   logic [2:0]        an_q, an_d;
   logic              frame_q, frame_d;

   logic [3:0]        w_digit;
   logic              w_blank;
   logic [2:0]        w_onehot;
   logic [6:0]        w_pat;

   function automatic logic [6:0] decode(input logic [3:0] v);
      case (v)
         4'd0:    decode = 7'h3F;
         4'd1:    decode = 7'h06;
         4'd2:    decode = 7'h5B;
         4'd3:    decode = 7'h4F;
         4'd4:    decode = 7'h66;
         4'd5:    decode = 7'h6D;
         4'd6:    decode = 7'h7D;
         4'd7:    decode = 7'h07;
         4'd8:    decode = 7'h7F;
         4'd9:    decode = 7'h6F;
         default: decode = 7'h40;
      endcase
   endfunction

   always_comb begin
      state_d        = state_q;
      presc_d        = presc_q;
      snap_d         = snap_q;
      load_pending_d = load_pending_q;
      frame_d        = 1'b0;
      if (load_pending_q) begin
         snap_d         = {d100, d10, d1};
         load_pending_d = 1'b0;
         state_d        = DIG0;
         presc_d        = '0;
         frame_d        = 1'b1;
      end else if (presc_q == c_TC) begin
         presc_d = '0;
         case (state_q)
            DIG0:    state_d = DIG1;
            DIG1:    state_d = DIG2;
            default: begin
               state_d = DIG0;
               snap_d  = {d100, d10, d1};
               frame_d = 1'b1;
            end
         endcase
      end else begin
         presc_d = presc_q + 1'b1;
      end
   end

   // Outputs are derived from the next state/snapshot so they register in step
   // with the slot change and no dead cycle appears between digits.
   always_comb begin
      w_digit  = snap_d[3:0];
      w_blank  = 1'b0;
      w_onehot = 3'b001;
      case (state_d)
         DIG1: begin
            w_digit  = snap_d[7:4];
            w_blank  = BLANK_LZ && (snap_d[11:8] == 4'd0) && (snap_d[7:4] == 4'd0);
            w_onehot = 3'b010;
         end
         DIG2: begin
            w_digit  = snap_d[11:8];
            w_blank  = BLANK_LZ && (snap_d[11:8] == 4'd0);
            w_onehot = 3'b100;
         end
         default: ;
      endcase
      w_pat = w_blank ? 7'h00 : decode(w_digit);
      seg_d = SEG_ACTIVE_LOW ? ~w_pat : w_pat;
      an_d  = AN_ACTIVE_LOW ? ~(w_blank ? 3'b000 : w_onehot)
                            :  (w_blank ? 3'b000 : w_onehot);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= DIG0;
         presc_q        <= '0;
         snap_q         <= '0;
         load_pending_q <= 1'b1;
         seg_q          <= c_SEG_OFF;
         an_q           <= c_AN_OFF;
         frame_q        <= 1'b0;
      end else begin
         state_q        <= state_d;
         presc_q        <= presc_d;
         snap_q         <= snap_d;
         load_pending_q <= load_pending_d;
         seg_q          <= seg_d;
         an_q           <= an_d;
         frame_q        <= frame_d;
      end
   end

   assign seg   = seg_q;
   assign an    = an_q;
   assign frame = frame_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd3_seg_scanner.sv
// ============================================================================
// Module   : tb_bcd3_seg_scanner
// Purpose  : Self-checking bench for bcd3_seg_scanner (REFRESH_DIV=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd3_seg_scanner;

   localparam int RD = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] d1, d10, d100;
   logic [6:0] seg, seg_nb;
   logic [2:0] an, an_nb;
   logic       frame, frame_nb;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   bcd3_seg_scanner #(.REFRESH_DIV(RD)) dut (
      .clk(clk), .reset(reset), .d1(d1), .d10(d10), .d100(d100),
      .seg(seg), .an(an), .frame(frame)
   );

   bcd3_seg_scanner #(.REFRESH_DIV(RD), .BLANK_LZ(1'b0)) dut_nb (
      .clk(clk), .reset(reset), .d1(d1), .d10(d10), .d100(d100),
      .seg(seg_nb), .an(an_nb), .frame(frame_nb)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: time since load decides the slot; snapshot every 3*RD cycles.
   int         m_t = 0;
   bit         m_inrst = 1'b0;
   bit         m_started = 1'b0;
   int         m_snap[3] = '{0, 0, 0};
   int         seg_tbl[16] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07,
                               'h7F, 'h6F, 'h40, 'h40, 'h40, 'h40, 'h40, 'h40};

   function automatic void expect_out(input int slot, input bit blank_en,
                                      output logic [6:0] s, output logic [2:0] a);
      bit blank;
      blank = blank_en && ((slot == 2 && m_snap[2] == 0) ||
                           (slot == 1 && m_snap[2] == 0 && m_snap[1] == 0));
      s = blank ? 7'h7F : 7'(~seg_tbl[m_snap[slot]]);
      a = blank ? 3'b111 : 3'(~(1 << slot));
   endfunction

   always @(posedge clk) begin
      logic [6:0] es;
      logic [2:0] ea;
      int slot;
      if (reset) begin
         m_started = 1'b1;
         m_inrst   = 1'b1;
      end else begin
         m_t     = m_inrst ? 0 : m_t + 1;
         m_inrst = 1'b0;
         if (m_t % (3 * RD) == 0)
            m_snap = '{int'(d1), int'(d10), int'(d100)};
      end
      #1;
      if (m_started) begin
         if (m_inrst) begin
            chk("m_rst_seg", seg, 7'h7F);
            chk("m_rst_an", an, 3'b111);
            chk("m_rst_frame", frame, 1'b0);
         end else begin
            slot = (m_t / RD) % 3;
            expect_out(slot, 1'b1, es, ea);
            chk("m_seg", seg, es);
            chk("m_an", an, ea);
            chk("m_frame", frame, (m_t % (3 * RD)) == 0);
            expect_out(slot, 1'b0, es, ea);
            chk("m_nb_seg", seg_nb, es);
            chk("m_nb_an", an_nb, ea);
         end
      end
   end

   task automatic restart(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
      @(negedge clk);
      reset = 1'b1;
      d100 = h; d10 = t; d1 = o;
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Packed expectations: {slot2, slot1, slot0}.
   task automatic check_frame(input string tag,
                              input logic [8:0] an_e, input logic [20:0] seg_e,
                              input logic [8:0] annb_e, input logic [20:0] segnb_e,
                              input int chg_at, input logic [3:0] chg_val);
      int s;
      for (int i = 0; i < 3 * RD; i++) begin
         @(posedge clk);
         #1;
         s = i / RD;
         chk({tag, "_an"}, an, an_e[s*3 +: 3]);
         chk({tag, "_seg"}, seg, seg_e[s*7 +: 7]);
         chk({tag, "_nb_an"}, an_nb, annb_e[s*3 +: 3]);
         chk({tag, "_nb_seg"}, seg_nb, segnb_e[s*7 +: 7]);
         chk({tag, "_frame"}, frame, i == 0);
         @(negedge clk);
         if (i == chg_at) d1 = chg_val;
      end
   endtask

   localparam logic [8:0] ALL_LIT = {3'b011, 3'b101, 3'b110};

   initial begin
      reset = 1'b1;
      d100 = 4'd9; d10 = 4'd9; d1 = 4'd9;
      repeat (3) begin
         @(negedge clk);
         chk("rst_an", an, 3'b111);
         chk("rst_seg", seg, 7'h7F);
         chk("rst_frame", frame, 1'b0);
      end
      reset = 1'b0;
      check_frame("nines", ALL_LIT, {7'h10, 7'h10, 7'h10}, ALL_LIT, {7'h10, 7'h10, 7'h10}, -1, 4'd0);

      restart(4'd3, 4'd2, 4'd1);
      check_frame("d321", ALL_LIT, {7'h30, 7'h24, 7'h79}, ALL_LIT, {7'h30, 7'h24, 7'h79}, -1, 4'd0);
      check_frame("d321b", ALL_LIT, {7'h30, 7'h24, 7'h79}, ALL_LIT, {7'h30, 7'h24, 7'h79}, -1, 4'd0);

      restart(4'd0, 4'd0, 4'd7);
      check_frame("d007", {3'b111, 3'b111, 3'b110}, {7'h7F, 7'h7F, 7'h78},
                  ALL_LIT, {7'h40, 7'h40, 7'h78}, -1, 4'd0);

      restart(4'd1, 4'd0, 4'd0);
      check_frame("d100", ALL_LIT, {7'h79, 7'h40, 7'h40}, ALL_LIT, {7'h79, 7'h40, 7'h40}, -1, 4'd0);

      // d1 changes mid-frame, two cycles into the tens slot.
      restart(4'd3, 4'd2, 4'd1);
      check_frame("hold", ALL_LIT, {7'h30, 7'h24, 7'h79}, ALL_LIT, {7'h30, 7'h24, 7'h79}, RD + 1, 4'd5);
      check_frame("reload", ALL_LIT, {7'h30, 7'h24, 7'h12}, ALL_LIT, {7'h30, 7'h24, 7'h12}, -1, 4'd0);

      restart(4'd0, 4'd12, 4'd4);
      check_frame("dash", {3'b111, 3'b101, 3'b110}, {7'h7F, 7'h3F, 7'h19},
                  ALL_LIT, {7'h40, 7'h3F, 7'h19}, -1, 4'd0);

      restart(4'd3, 4'd2, 4'd1);
      repeat (RD + 2) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst_an", an, 3'b111);
      chk("midrst_seg", seg, 7'h7F);
      chk("midrst_frame", frame, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("restart_frame", frame, 1'b1);
      chk("restart_an", an, 3'b110);
      chk("restart_seg", seg, 7'h79);

      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         reset = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 5) == 0) d1   = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 5) == 0) d10  = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
         if ($urandom_range(0, 5) == 0) d100 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      end
      reset = 1'b0;
      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/bcd3_seg_scanner.md
Name: bcd3_seg_scanner

Overview:
- Time-multiplexed 3-digit seven-segment display driver.
- Sits directly downstream of the 3-digit BCD counter and consumes its ones/tens/hundreds nibbles.
- Scans one digit per refresh slot and snapshots the three inputs once per frame, so a digit never changes while the frame is being shown.
- Blanks leading zeros and shows a dash for non-BCD codes.

Parameters:
- REFRESH_DIV, 50000: clock cycles each digit is lit. Legal range 2..2^20. Prescaler width is ceil(log2(REFRESH_DIV)).
- SEG_ACTIVE_LOW, 1: 1 = seg outputs inverted (segment on = 0).
- AN_ACTIVE_LOW, 1: 1 = an outputs inverted (digit on = 0).
- BLANK_LZ, 1: 1 = leading-zero blanking enabled.

Ports:
- clk, in, 1: system clock; all logic on its rising edge.
- reset, in, 1: synchronous, active-high reset.
- d1, in, 4: ones BCD digit.
- d10, in, 4: tens BCD digit.
- d100, in, 4: hundreds BCD digit.
- seg, out, 7: segments {g,f,e,d,c,b,a}; seg[0] = a.
- an, out, 3: digit enables; an[0] = ones, an[1] = tens, an[2] = hundreds.
- frame, out, 1: one-cycle pulse on each snapshot load.

Behaviour:
- Reset is one clock, synchronous, active-high. While reset is high, at each edge:
  - prescaler = 0, state = DIG0, snapshots = 0, load_pending = 1.
  - an = all digits off (3'b111 with defaults), seg = all off (7'h7F with defaults), frame = 0.
- Reset asserted mid-frame blanks the outputs at the next edge. No partial slot is resumed.
- Post-reset load:
  - First edge with reset low: snapshot loads {d100, d10, d1}, load_pending clears, state = DIG0, prescaler = 0.
  - Outputs drive DIG0 from the new snapshot, and frame = 1 for that cycle.
- Prescaler: counts 0..REFRESH_DIV-1. At terminal count it wraps to 0 and the state advances at the same edge.
- State machine: DIG0 (ones) -> DIG1 (tens) -> DIG2 (hundreds) -> DIG0.
- DIG2->DIG0 transition: the snapshot reloads from the inputs at the same edge, and frame is high for the following cycle.
- Inputs are ignored at all other edges.
- seg and an are registered and computed from next-state/next-snapshot values:
  - Each digit is lit exactly REFRESH_DIV cycles.
  - Frame period is 3*REFRESH_DIV cycles.
  - No dead cycle between slots.
- Decode (active-high internal pattern, then inverted if SEG_ACTIVE_LOW):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Codes 10..15 = 40 (dash).
- Leading-zero blanking (BLANK_LZ=1):
  - Hundreds is blanked if snap100 == 0.
  - Tens is blanked if snap100 == 0 and snap10 == 0.
  - Ones is never blanked.
  - Invalid codes count as non-zero.
- Blanked slot: its an bit stays off and seg = all off, but the slot still lasts REFRESH_DIV cycles.
- BLANK_LZ=0: no blanking.
- Exactly one an bit is active in a non-blanked slot. Never more than one is active.

Test Plan (REFRESH_DIV=4, all other parameters default):
- Reset held 3 cycles with d=9,9,9:
  - During reset: an=111, seg=7F, frame=0.
  - First cycle after release: frame=1, an=110, seg=10 (digit 9).
- d100=3, d10=2, d1=1:
  - an=110/seg=79 for 4 cycles, then an=101/seg=24 for 4, then an=011/seg=30 for 4.
  - frame pulses every 12 cycles.
- d100=0, d10=0, d1=7:
  - an=110/seg=78 for 4 cycles, then an=111/seg=7F for 8 cycles.
  - Repeat with BLANK_LZ=0: all three digits lit; tens and hundreds show seg=40.
- d100=1, d10=0, d1=0: all three digits lit. Ones and tens show seg=40, hundreds shows seg=79.
- Change d1 from 1 to 5 two cycles into the DIG1 slot:
  - Ones still shows 1 until the next frame pulse.
  - The ones slot after the pulse shows seg=12.
- d10=12 (invalid), d100=0: tens shows a dash (seg=3F) and is not blanked.
- Assert reset for 1 cycle mid-DIG1: outputs blank for that cycle, then restart at DIG0 with frame=1.
